// File: rtl/demux2_stream.sv
// -----------------------------------------------------------------------------
// demux2_stream
//   Registered 1-to-2 demultiplexer for operand words. It steers each word of a
//   single valid/ready stream into one of two holding registers that feed the
//   operand buffers of the multiply core. It is the inverse of the 2-input
//   operand mux.
//
//   There are two routing modes:
//     mode = 0 : manual routing, where sel picks the destination of each word.
//     mode = 1 : auto routing, where bursts of BURST_LEN words alternate
//                between out1 and out2.
//
// State table (auto FSM)
//   state | meaning
//   A1    | auto target is out1
//   A2    | auto target is out2
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_data/in_valid/in_ready   upstream stream
//   mode, sel                   routing controls
//   out1_data/valid/ready       destination 1 stream
//   out2_data/valid/ready       destination 2 stream
//   cur_dest                    destination of the next accepted word
//   burst_cnt                   words accepted in the current auto burst
// -----------------------------------------------------------------------------
module demux2_stream #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic              sel,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out2_data,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic              cur_dest,
    output logic [7:0]        burst_cnt
);

    typedef enum logic {
        ST_A1 = 1'b0,
        ST_A2 = 1'b1
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(BURST_LEN - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_mode_q;
    logic [DATA_W-1:0] r_out1_data;
    logic [DATA_W-1:0] r_out2_data;
    logic              r_out1_valid;
    logic              r_out2_valid;

    logic              w_free1;
    logic              w_free2;
    logic              w_target;
    logic              w_xfer;
    logic              w_load1;
    logic              w_load2;
    logic [7:0]        w_cnt_eff;

    // A holding register is free when it is empty, or when it drains in the
    // same cycle that it would load.
    assign w_free1  = !r_out1_valid || out1_ready;
    assign w_free2  = !r_out2_valid || out2_ready;
    assign w_target = mode ? r_state : sel;

    assign in_ready = rst_n && (w_target ? w_free2 : w_free1);
    assign w_xfer   = in_valid && in_ready;
    assign w_load1  = w_xfer && !w_target;
    assign w_load2  = w_xfer &&  w_target;

    // The count register holds its value while in manual mode. It reads as 0
    // in manual mode and on the first auto cycle after a manual stretch, so
    // every burst restarts from 0 when auto mode is re-entered.
    assign w_cnt_eff = (mode && r_mode_q) ? r_cnt : 8'd0;

    assign cur_dest  = rst_n && w_target;
    assign burst_cnt = w_cnt_eff;

    assign out1_data  = r_out1_data;
    assign out1_valid = r_out1_valid;
    assign out2_data  = r_out2_data;
    assign out2_valid = r_out2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_A1;
            r_cnt        <= 8'd0;
            r_mode_q     <= 1'b0;
            r_out1_data  <= '0;
            r_out2_data  <= '0;
            r_out1_valid <= 1'b0;
            r_out2_valid <= 1'b0;
        end else begin
            r_mode_q <= mode;

            if (w_load1) begin
                r_out1_data  <= in_data;
                r_out1_valid <= 1'b1;
            end else if (r_out1_valid && out1_ready) begin
                r_out1_valid <= 1'b0;
            end

            if (w_load2) begin
                r_out2_data  <= in_data;
                r_out2_valid <= 1'b1;
            end else if (r_out2_valid && out2_ready) begin
                r_out2_valid <= 1'b0;
            end

            if (mode) begin
                if (w_xfer) begin
                    if (w_cnt_eff == LP_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= (r_state == ST_A1) ? ST_A2 : ST_A1;
                    end else begin
                        r_cnt <= w_cnt_eff + 8'd1;
                    end
                end else begin
                    r_cnt <= w_cnt_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux2_stream.sv
module tb_demux2_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic        sel;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
    logic        cur_dest;
    logic [7:0]  burst_cnt;

    int checks   = 0;
    int failures = 0;

    demux2_stream #(.DATA_W(16), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .sel        (sel),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cur_dest   (cur_dest),
        .burst_cnt  (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic        sel;
        logic        valid;
        logic [15:0] data;
        logic        r1;
        logic        r2;
        logic        e_rdy;
        logic        e_dest;
        logic [7:0]  e_cnt;
        logic        e_v1;
        logic [15:0] e_d1;
        logic        e_v2;
        logic [15:0] e_d2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    // Starts at posedge+1: drive, check the combinational outputs, clock once,
    // then check the registered outputs at posedge+1.
    task automatic apply(input vec_t v, input int idx);
        mode       = v.mode;
        sel        = v.sel;
        in_valid   = v.valid;
        in_data    = v.data;
        out1_ready = v.r1;
        out2_ready = v.r2;
        #1;
        chk("in_ready",  idx, {31'd0, in_ready},  {31'd0, v.e_rdy});
        chk("cur_dest",  idx, {31'd0, cur_dest},  {31'd0, v.e_dest});
        chk("burst_cnt", idx, {24'd0, burst_cnt}, {24'd0, v.e_cnt});
        @(posedge clk);
        #1;
        chk("out1_valid", idx, {31'd0, out1_valid}, {31'd0, v.e_v1});
        chk("out1_data",  idx, {16'd0, out1_data},  {16'd0, v.e_d1});
        chk("out2_valid", idx, {31'd0, out2_valid}, {31'd0, v.e_v2});
        chk("out2_data",  idx, {16'd0, out2_data},  {16'd0, v.e_d2});
    endtask

    task automatic chk_reset_state(input int idx);
        chk("rst_out1_valid", idx, {31'd0, out1_valid}, 32'd0);
        chk("rst_out2_valid", idx, {31'd0, out2_valid}, 32'd0);
        chk("rst_out1_data",  idx, {16'd0, out1_data},  32'd0);
        chk("rst_out2_data",  idx, {16'd0, out2_data},  32'd0);
        chk("rst_in_ready",   idx, {31'd0, in_ready},   32'd0);
        chk("rst_cur_dest",   idx, {31'd0, cur_dest},   32'd0);
        chk("rst_burst_cnt",  idx, {24'd0, burst_cnt},  32'd0);
    endtask

    initial begin
        // mode sel vld data r1 r2 | rdy dest cnt | v1 d1 v2 d2
        // manual routing
        vecs.push_back('{1'b0,1'b0,1'b1,16'd10, 1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b1,16'd10, 1'b0,16'd0});
        vecs.push_back('{1'b0,1'b1,1'b1,16'd1,  1'b1,1'b1, 1'b1,1'b1,8'd0, 1'b0,16'd10, 1'b1,16'd1});
        vecs.push_back('{1'b0,1'b0,1'b1,16'd231,1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b1,16'd231,1'b0,16'd1});
        vecs.push_back('{1'b0,1'b0,1'b0,16'd0,  1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b0,16'd231,1'b0,16'd1});
        // auto burst, words 1..10
        vecs.push_back('{1'b1,1'b0,1'b1,16'd1,  1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b1,16'd1, 1'b0,16'd1});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd2,  1'b1,1'b1, 1'b1,1'b0,8'd1, 1'b1,16'd2, 1'b0,16'd1});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd3,  1'b1,1'b1, 1'b1,1'b0,8'd2, 1'b1,16'd3, 1'b0,16'd1});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd4,  1'b1,1'b1, 1'b1,1'b0,8'd3, 1'b1,16'd4, 1'b0,16'd1});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd5,  1'b1,1'b1, 1'b1,1'b1,8'd0, 1'b0,16'd4, 1'b1,16'd5});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd6,  1'b1,1'b1, 1'b1,1'b1,8'd1, 1'b0,16'd4, 1'b1,16'd6});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd7,  1'b1,1'b1, 1'b1,1'b1,8'd2, 1'b0,16'd4, 1'b1,16'd7});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd8,  1'b1,1'b1, 1'b1,1'b1,8'd3, 1'b0,16'd4, 1'b1,16'd8});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd9,  1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b1,16'd9, 1'b0,16'd8});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd10, 1'b1,1'b1, 1'b1,1'b0,8'd1, 1'b1,16'd10,1'b0,16'd8});
        vecs.push_back('{1'b1,1'b0,1'b0,16'd0,  1'b1,1'b1, 1'b1,1'b0,8'd2, 1'b0,16'd10,1'b0,16'd8});
        // mode switch: manual words to out2, then auto restarts its burst
        vecs.push_back('{1'b0,1'b1,1'b1,16'd100,1'b1,1'b1, 1'b1,1'b1,8'd0, 1'b0,16'd10,1'b1,16'd100});
        vecs.push_back('{1'b0,1'b1,1'b1,16'd101,1'b1,1'b1, 1'b1,1'b1,8'd0, 1'b0,16'd10,1'b1,16'd101});
        vecs.push_back('{1'b0,1'b1,1'b1,16'd102,1'b1,1'b1, 1'b1,1'b1,8'd0, 1'b0,16'd10,1'b1,16'd102});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd200,1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b1,16'd200,1'b0,16'd102});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd201,1'b1,1'b1, 1'b1,1'b0,8'd1, 1'b1,16'd201,1'b0,16'd102});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd202,1'b1,1'b1, 1'b1,1'b0,8'd2, 1'b1,16'd202,1'b0,16'd102});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd203,1'b1,1'b1, 1'b1,1'b0,8'd3, 1'b1,16'd203,1'b0,16'd102});
        vecs.push_back('{1'b1,1'b0,1'b1,16'd204,1'b1,1'b1, 1'b1,1'b1,8'd0, 1'b0,16'd203,1'b1,16'd204});
        vecs.push_back('{1'b0,1'b0,1'b0,16'd0,  1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b0,16'd203,1'b0,16'd204});

        rst_n      = 1'b1;
        mode       = 1'b0;
        sel        = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'd0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;

        // asynchronous reset mid-cycle, before any clock edge
        #2 rst_n = 1'b0;
        #1 chk_reset_state(0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready", 0, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i], i);

        // backpressure: out1 stalls, out2 still accepts
        apply('{1'b0,1'b0,1'b1,16'd5,1'b0,1'b1, 1'b1,1'b0,8'd0, 1'b1,16'd5,1'b0,16'd204}, 100);
        apply('{1'b0,1'b0,1'b1,16'd6,1'b0,1'b1, 1'b0,1'b0,8'd0, 1'b1,16'd5,1'b0,16'd204}, 101);
        apply('{1'b0,1'b1,1'b1,16'd7,1'b0,1'b1, 1'b1,1'b1,8'd0, 1'b1,16'd5,1'b1,16'd7},   102);
        apply('{1'b0,1'b1,1'b0,16'd0,1'b1,1'b1, 1'b1,1'b1,8'd0, 1'b0,16'd5,1'b0,16'd7},   103);

        // reset mid-operation with a word stuck in out2 (FSM currently in A2)
        apply('{1'b0,1'b1,1'b1,16'd9,1'b1,1'b0, 1'b1,1'b1,8'd0, 1'b0,16'd5,1'b1,16'd9},   200);
        mode       = 1'b1;
        in_valid   = 1'b0;
        out2_ready = 1'b0;
        #1 chk("pre_rst_cur_dest", 201, {31'd0, cur_dest}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_state(202);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply('{1'b1,1'b0,1'b1,16'd42,1'b1,1'b1, 1'b1,1'b0,8'd0, 1'b1,16'd42,1'b0,16'd0}, 203);
        apply('{1'b1,1'b0,1'b1,16'd43,1'b1,1'b1, 1'b1,1'b0,8'd1, 1'b1,16'd43,1'b0,16'd0}, 204);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
